// File: rtl/alu_uart_if_if.sv
// Bus between the UART/ALU sequencing stage and its surroundings.
// The slave modport is the sequencer's view; master is the driving environment.
interface alu_uart_if_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [7:0]         i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_ctrl;
    logic [7:0]         o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_timeout;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_data_a, o_data_b, o_ctrl, o_tx_data, o_tx_start, o_busy, o_timeout
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_data_a, o_data_b, o_ctrl, o_tx_data, o_tx_start, o_busy, o_timeout
    );
endinterface

// File: rtl/alu_uart_if.sv
// Byte-serial front end for the combinational ALU: gathers A, B, opcode from the
// UART receiver and returns the result via the transmitter. Optional ALU_IF_TIMEOUT_EN.
module alu_uart_if #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    alu_uart_if_if.slave        bus
);
    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX
    } state_e;

    if (NB_DATA != 8 || NB_OP > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("alu_uart_if: NB_DATA must be 8, NB_OP <= 8, TIMEOUT_CYCLES >= 2");
    end

    state_e             state_q;
    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_b_q;
    logic [NB_OP-1:0]   ctrl_q;
    logic [7:0]         tx_data_q;
    logic               tx_start_q;

`ifdef ALU_IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
`endif

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            ctrl_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
`endif
            unique case (state_q)
                WAIT_A: begin
                    if (bus.i_rx_done) begin
                        data_a_q <= bus.i_rx_data;
                        state_q  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.i_rx_done) begin
                        data_b_q <= bus.i_rx_data;
                        state_q  <= WAIT_OP;
                    end
`ifdef ALU_IF_TIMEOUT_EN
                    else if (cnt_q == CNT_TERM) begin
                        state_q   <= WAIT_A;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        ctrl_q  <= bus.i_rx_data[NB_OP-1:0];
                        state_q <= CALC;
                    end
`ifdef ALU_IF_TIMEOUT_EN
                    else if (cnt_q == CNT_TERM) begin
                        state_q   <= WAIT_A;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                CALC: begin
                    // The ALU has seen the registered operands for a full cycle.
                    tx_data_q  <= bus.i_alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    state_q <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        state_q <= WAIT_A;
                    end
                end
                default: begin
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_data_a   = data_a_q;
    assign bus.o_data_b   = data_b_q;
    assign bus.o_ctrl     = ctrl_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = (state_q == CALC) || (state_q == SEND) || (state_q == WAIT_TX);
`ifdef ALU_IF_TIMEOUT_EN
    assign bus.o_timeout  = timeout_q;
`else
    assign bus.o_timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_uart_if.sv
// Directed self-checking bench for alu_uart_if; covers the timeout path
// when ALU_IF_TIMEOUT_EN is defined (TIMEOUT_CYCLES overridden to 16).
module tb_alu_uart_if;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    alu_uart_if_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    alu_uart_if #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        tick();
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
    endtask

    task automatic pulse_tx_done();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a"},     32'(bus.o_data_a),   32'h0);
        check({tag, "_b"},     32'(bus.o_data_b),   32'h0);
        check({tag, "_ctrl"},  32'(bus.o_ctrl),     32'h0);
        check({tag, "_txd"},   32'(bus.o_tx_data),  32'h0);
        check({tag, "_start"}, 32'(bus.o_tx_start), 32'h0);
        check({tag, "_busy"},  32'(bus.o_busy),     32'h0);
        check({tag, "_tmo"},   32'(bus.o_timeout),  32'h0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset             = 1'b1;
        bus.i_rx_data     = 8'h00;
        bus.i_rx_done     = 1'b0;
        bus.i_tx_done     = 1'b0;
        bus.i_alu_result  = 8'h08;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("rst");

        // Transaction 1: 5, 3, op 0x20, stub result 0x08.
        send_byte(8'h05);
        check("t1_a", 32'(bus.o_data_a), 32'h05);
        check("t1_busy_b", 32'(bus.o_busy), 32'h0);
        send_byte(8'h03);
        check("t1_b", 32'(bus.o_data_b), 32'h03);
        send_byte(8'h20);
        check("t1_ctrl", 32'(bus.o_ctrl), 32'h20);
        check("t1_busy_calc", 32'(bus.o_busy), 32'h1);
        check("t1_start_calc", 32'(bus.o_tx_start), 32'h0);
        tick();
        check("t1_start", 32'(bus.o_tx_start), 32'h1);
        check("t1_txd", 32'(bus.o_tx_data), 32'h08);
        tick();
        check("t1_start_end", 32'(bus.o_tx_start), 32'h0);
        check("t1_busy_wtx", 32'(bus.o_busy), 32'h1);
        tick();
        tick();
        check("t1_busy_hold", 32'(bus.o_busy), 32'h1);
        check("t1_start_hold", 32'(bus.o_tx_start), 32'h0);

        // Byte 0x77 in WAIT_TX is dropped.
        send_byte(8'h77);
        check("drop_a", 32'(bus.o_data_a), 32'h05);
        check("drop_busy", 32'(bus.o_busy), 32'h1);
        pulse_tx_done();
        check("t1_idle", 32'(bus.o_busy), 32'h0);

        // Transaction 2: 0x11, 0x22, opcode 0xE2 -> ctrl 0x22, result 0x5A.
        bus.i_alu_result = 8'h5A;
        send_byte(8'h11);
        check("t2_a", 32'(bus.o_data_a), 32'h11);
        check("t2_b_hold", 32'(bus.o_data_b), 32'h03);
        send_byte(8'h22);
        send_byte(8'hE2);
        check("t2_ctrl", 32'(bus.o_ctrl), 32'h22);
        tick();
        check("t2_start", 32'(bus.o_tx_start), 32'h1);
        check("t2_txd", 32'(bus.o_tx_data), 32'h5A);
        tick();
        pulse_tx_done();
        check("t2_idle", 32'(bus.o_busy), 32'h0);

        // Reset in WAIT_OP discards the partial transaction.
        send_byte(8'h0A);
        send_byte(8'h0B);
        check("p_b", 32'(bus.o_data_b), 32'h0B);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("mid_rst");
        tick();
        tick();
        check("mid_rst_nostart", 32'(bus.o_tx_start), 32'h0);

        // Fresh transaction after reset.
        bus.i_alu_result = 8'h03;
        send_byte(8'h01);
        send_byte(8'h02);
        check("t3_busy_op", 32'(bus.o_busy), 32'h0);
        send_byte(8'h03);
        check("t3_a", 32'(bus.o_data_a), 32'h01);
        check("t3_b", 32'(bus.o_data_b), 32'h02);
        check("t3_ctrl", 32'(bus.o_ctrl), 32'h03);
        tick();
        check("t3_start", 32'(bus.o_tx_start), 32'h1);
        check("t3_txd", 32'(bus.o_tx_data), 32'h03);
        tick();

        // rx and tx_done together in WAIT_TX: back to WAIT_A, byte dropped.
        bus.i_tx_done = 1'b1;
        send_byte(8'h44);
        bus.i_tx_done = 1'b0;
        check("sim_busy", 32'(bus.o_busy), 32'h0);
        check("sim_a", 32'(bus.o_data_a), 32'h01);
        send_byte(8'h66);
        check("sim_next_a", 32'(bus.o_data_a), 32'h66);
        check("sim_next_b", 32'(bus.o_data_b), 32'h02);

        // Inter-byte idle in WAIT_B.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_byte(8'h01);
        check("tmo_a", 32'(bus.o_data_a), 32'h01);
`ifdef ALU_IF_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check("tmo_early", 32'(bus.o_timeout), 32'h0);
        end
        tick();
        check("tmo_pulse", 32'(bus.o_timeout), 32'h1);
        tick();
        check("tmo_pulse_end", 32'(bus.o_timeout), 32'h0);
        send_byte(8'h09);
        check("tmo_new_a", 32'(bus.o_data_a), 32'h09);
        check("tmo_b_stale", 32'(bus.o_data_b), 32'h00);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("notmo_low", 32'(bus.o_timeout), 32'h0);
        end
        send_byte(8'h09);
        check("notmo_a", 32'(bus.o_data_a), 32'h01);
        check("notmo_b", 32'(bus.o_data_b), 32'h09);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
